// File: rtl/fifo_ext_if.sv
// Handshake bundle for fifo_ext: control, write and read sides plus status.
// The user side drives through master; the FIFO itself binds to slave.
interface fifo_ext_if #(
  parameter int DW = 8,
  parameter int LW = 5
);
  logic          clk_en_i;
  logic          clr_i;
  logic          w_en_i;
  logic [DW-1:0] w_data_i;
  logic          r_en_i;
  logic [DW-1:0] r_data_o;
  logic          r_valid_o;
  logic          w_full_o;
  logic          r_empty_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          underflow_o;

  modport master (
    output clk_en_i, clr_i, w_en_i, w_data_i, r_en_i,
    input  r_data_o, r_valid_o, w_full_o, r_empty_o,
    input  almost_full_o, almost_empty_o, level_o, overflow_o, underflow_o
  );

  modport slave (
    input  clk_en_i, clr_i, w_en_i, w_data_i, r_en_i,
    output r_data_o, r_valid_o, w_full_o, r_empty_o,
    output almost_full_o, almost_empty_o, level_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_ext.sv
// Synchronous FIFO with occupancy level, almost-full/empty thresholds, sticky
// overflow/underflow flags and a choice of registered or first-word-fall-through read.
module fifo_ext #(
  parameter int data_word_size_g      = 8,
  parameter int num_fifo_elements_g   = 16,
  parameter int fwft_mode_g           = 0,
  parameter int almost_full_thresh_g  = num_fifo_elements_g - 2,
  parameter int almost_empty_thresh_g = 2
) (
  input logic       clk_i,
  input logic       rst_i,
  fifo_ext_if.slave bus
);

  localparam int DW    = data_word_size_g;
  localparam int DEPTH = num_fifo_elements_g;
  localparam int AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(almost_full_thresh_g);
  localparam logic [LW-1:0] AE_L    = LW'(almost_empty_thresh_g);

  // Reject illegal parameterisations at elaboration time.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_ext: num_fifo_elements_g must be a power of two >= 2");
  end
  if (DW < 1 || DW > 256) begin : g_bad_width
    $error("fifo_ext: data_word_size_g must be in 1..256");
  end
  if (fwft_mode_g != 0 && fwft_mode_g != 1) begin : g_bad_mode
    $error("fifo_ext: fwft_mode_g must be 0 or 1");
  end
  if (almost_full_thresh_g < 1 || almost_full_thresh_g > DEPTH - 1) begin : g_bad_af
    $error("fifo_ext: almost_full_thresh_g out of range");
  end
  if (almost_empty_thresh_g < 1 || almost_empty_thresh_g > DEPTH - 1) begin : g_bad_ae
    $error("fifo_ext: almost_empty_thresh_g out of range");
  end

  logic [DW-1:0] mem [0:DEPTH-1];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0] wr_ptr_next, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          overflow_reg, underflow_reg;
  logic          full, empty;
  logic          active, wr_accept, rd_accept;
  logic [DW-1:0] r_data;
  logic          r_valid;

  // Status flags decode only the registered level.
  assign full  = (level_reg == DEPTH_L);
  assign empty = (level_reg == '0);

  assign active    = bus.clk_en_i & ~bus.clr_i;
  assign wr_accept = active & bus.w_en_i & ~full;
  assign rd_accept = active & bus.r_en_i & ~empty;

  always_comb begin
    wr_ptr_next = wr_accept ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = rd_accept ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    level_next  = level_reg;
    case ({wr_accept, rd_accept})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (bus.clk_en_i) begin
      if (bus.clr_i) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        level_reg     <= '0;
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        level_reg  <= level_next;
        if (bus.w_en_i && full) overflow_reg <= 1'b1;
        if (bus.r_en_i && empty) underflow_reg <= 1'b1;
      end
    end
  end

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem[wr_ptr_reg] <= bus.w_data_i;
  end

  if (fwft_mode_g == 1) begin : g_fwft
    logic [DW-1:0] head_reg;

    // Prefetch the word at the next head address; bypass the array when that
    // slot is being written this very cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        head_reg <= '0;
      end else if (active) begin
        if (wr_accept && (wr_ptr_reg == rd_ptr_next)) head_reg <= bus.w_data_i;
        else                                          head_reg <= mem[rd_ptr_next];
      end
    end

    assign r_data  = head_reg;
    assign r_valid = ~empty;
  end else begin : g_std
    logic [DW-1:0] r_data_reg;
    logic          r_valid_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_data_reg  <= '0;
        r_valid_reg <= 1'b0;
      end else if (bus.clk_en_i) begin
        if (bus.clr_i) begin
          r_valid_reg <= 1'b0;
        end else begin
          r_valid_reg <= rd_accept;
          if (rd_accept) r_data_reg <= mem[rd_ptr_reg];
        end
      end
    end

    assign r_data  = r_data_reg;
    assign r_valid = r_valid_reg;
  end

  assign bus.r_data_o       = r_data;
  assign bus.r_valid_o      = r_valid;
  assign bus.w_full_o       = full;
  assign bus.r_empty_o      = empty;
  assign bus.almost_full_o  = (level_reg >= AF_L);
  assign bus.almost_empty_o = (level_reg <= AE_L);
  assign bus.level_o        = level_reg;
  assign bus.overflow_o     = overflow_reg;
  assign bus.underflow_o    = underflow_reg;

endmodule

// File: tb/tb_fifo_ext.sv
// Directed bench for fifo_ext: a standard-mode instance driven from a vector
// table plus hand sequences, and a FWFT instance for the fall-through cases.
module tb_fifo_ext;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_ext_if #(.DW(8), .LW(5)) bus_std ();
  fifo_ext_if #(.DW(8), .LW(5)) bus_fw ();

  fifo_ext #(
    .data_word_size_g(8), .num_fifo_elements_g(16), .fwft_mode_g(0),
    .almost_full_thresh_g(14), .almost_empty_thresh_g(2)
  ) dut_std (
    .clk_i(clk), .rst_i(rst_n), .bus(bus_std)
  );

  fifo_ext #(
    .data_word_size_g(8), .num_fifo_elements_g(16), .fwft_mode_g(1),
    .almost_full_thresh_g(14), .almost_empty_thresh_g(2)
  ) dut_fw (
    .clk_i(clk), .rst_i(rst_n), .bus(bus_fw)
  );

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] wd;
    int         lvl;
    logic       vld;
    logic [7:0] d;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(logic w, logic r, logic [7:0] wd, int lvl,
                              logic vld, logic [7:0] d, logic ovf, logic udf);
    vec_t v;
    v.w = w; v.r = r; v.wd = wd; v.lvl = lvl;
    v.vld = vld; v.d = d; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_std(logic clr, logic w, logic r, logic [7:0] wd);
    bus_std.clr_i    = clr;
    bus_std.w_en_i   = w;
    bus_std.r_en_i   = r;
    bus_std.w_data_i = wd;
  endtask

  task automatic drive_fw(logic w, logic r, logic [7:0] wd);
    bus_fw.w_en_i   = w;
    bus_fw.r_en_i   = r;
    bus_fw.w_data_i = wd;
  endtask

  // Depth 16, almost-full at 14, almost-empty at 2.
  task automatic check_std(string tag, int lvl, logic vld, logic [7:0] d, logic ovf, logic udf);
    $display("std %s: level=%0d valid=%0b data=0x%02h ovf=%0b udf=%0b",
             tag, bus_std.level_o, bus_std.r_valid_o, bus_std.r_data_o,
             bus_std.overflow_o, bus_std.underflow_o);
    check({tag, " level"}, 32'(bus_std.level_o), 32'(lvl));
    check({tag, " full"}, 32'(bus_std.w_full_o), 32'(lvl == 16));
    check({tag, " empty"}, 32'(bus_std.r_empty_o), 32'(lvl == 0));
    check({tag, " almost_full"}, 32'(bus_std.almost_full_o), 32'(lvl >= 14));
    check({tag, " almost_empty"}, 32'(bus_std.almost_empty_o), 32'(lvl <= 2));
    check({tag, " valid"}, 32'(bus_std.r_valid_o), 32'(vld));
    check({tag, " data"}, 32'(bus_std.r_data_o), 32'(d));
    check({tag, " overflow"}, 32'(bus_std.overflow_o), 32'(ovf));
    check({tag, " underflow"}, 32'(bus_std.underflow_o), 32'(udf));
  endtask

  task automatic check_fw(string tag, int lvl, logic [7:0] d);
    $display("fwft %s: level=%0d valid=%0b data=0x%02h",
             tag, bus_fw.level_o, bus_fw.r_valid_o, bus_fw.r_data_o);
    check({tag, " fw level"}, 32'(bus_fw.level_o), 32'(lvl));
    check({tag, " fw valid"}, 32'(bus_fw.r_valid_o), 32'(lvl != 0));
    check({tag, " fw empty"}, 32'(bus_fw.r_empty_o), 32'(lvl == 0));
    if (lvl != 0) check({tag, " fw data"}, 32'(bus_fw.r_data_o), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Fill 16, overflow attempt, drain 16, underflow attempt, idle.
    n = 0;
    for (int i = 0; i < 16; i++) begin
      vecs[n] = mk(1'b1, 1'b0, 8'(i + 1), i + 1, 1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    vecs[n] = mk(1'b1, 1'b0, 8'h11, 16, 1'b0, 8'h00, 1'b1, 1'b0); n++;
    for (int i = 0; i < 16; i++) begin
      vecs[n] = mk(1'b0, 1'b1, 8'h00, 15 - i, 1'b1, 8'(i + 1), 1'b1, 1'b0);
      n++;
    end
    vecs[n] = mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h10, 1'b1, 1'b1); n++;
    vecs[n] = mk(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h10, 1'b1, 1'b1); n++;

    bus_std.clk_en_i = 1'b1;
    bus_fw.clk_en_i  = 1'b1;
    bus_fw.clr_i     = 1'b0;
    drive_std(1'b0, 1'b0, 1'b0, 8'h00);
    drive_fw(1'b0, 1'b0, 8'h00);

    #12;
    check_std("reset", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_fw("reset", 0, 8'h00);
    #5 rst_n = 1'b1;

    for (int i = 0; i < n; i++) begin
      drive_std(1'b0, vecs[i].w, vecs[i].r, vecs[i].wd);
      tick();
      check_std($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].vld, vecs[i].d,
                vecs[i].ovf, vecs[i].udf);
    end

    // Flush clears the sticky flags; then steady state at level 5 across wrap.
    drive_std(1'b1, 1'b0, 1'b0, 8'h00); tick();
    check_std("clr", 0, 1'b0, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_std(1'b0, 1'b1, 1'b0, 8'(8'h20 + i)); tick();
      check_std($sformatf("prefill%0d", i), i + 1, 1'b0, 8'h10, 1'b0, 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      drive_std(1'b0, 1'b1, 1'b1, 8'(8'h25 + k)); tick();
      check_std($sformatf("rw%0d", k), 5, 1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    end

    // Level 7, then flush with a concurrent write that must be dropped.
    drive_std(1'b0, 1'b1, 1'b0, 8'h40); tick();
    check_std("w40", 6, 1'b0, 8'h33, 1'b0, 1'b0);
    drive_std(1'b0, 1'b1, 1'b0, 8'h41); tick();
    check_std("w41", 7, 1'b0, 8'h33, 1'b0, 1'b0);
    drive_std(1'b1, 1'b1, 1'b0, 8'h99); tick();
    check_std("clr_w", 0, 1'b0, 8'h33, 1'b0, 1'b0);
    drive_std(1'b0, 1'b0, 1'b0, 8'h00); tick();
    check_std("post_clr", 0, 1'b0, 8'h33, 1'b0, 1'b0);
    drive_std(1'b0, 1'b1, 1'b0, 8'h55); tick();
    check_std("w55", 1, 1'b0, 8'h33, 1'b0, 1'b0);
    drive_std(1'b0, 1'b0, 1'b1, 8'h00); tick();
    check_std("r55", 0, 1'b1, 8'h55, 1'b0, 1'b0);
    drive_std(1'b0, 1'b0, 1'b1, 8'h00); tick();
    check_std("r_empty", 0, 1'b0, 8'h55, 1'b0, 1'b1);

    // Level 9, clock enable low holds everything, then async reset mid-cycle.
    for (int i = 0; i < 9; i++) begin
      drive_std(1'b0, 1'b1, 1'b0, 8'(8'h60 + i)); tick();
      check_std($sformatf("fill9_%0d", i), i + 1, 1'b0, 8'h55, 1'b0, 1'b1);
    end
    bus_std.clk_en_i = 1'b0;
    drive_std(1'b1, 1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_std($sformatf("ce_off%0d", i), 9, 1'b0, 8'h55, 1'b0, 1'b1);
    end
    bus_std.clk_en_i = 1'b1;
    drive_std(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1 check_std("mid_reset", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    drive_std(1'b0, 1'b1, 1'b0, 8'h77); tick();
    check_std("first_w", 1, 1'b0, 8'h00, 1'b0, 1'b0);
    drive_std(1'b0, 1'b0, 1'b1, 8'h00); tick();
    check_std("first_r", 0, 1'b1, 8'h77, 1'b0, 1'b0);
    drive_std(1'b0, 1'b0, 1'b0, 8'h00);

    // First-word-fall-through: appearance without r_en, pop, and bypass at level 1.
    drive_fw(1'b1, 1'b0, 8'hA5); tick();
    check_fw("wA5", 1, 8'hA5);
    drive_fw(1'b0, 1'b0, 8'h00); tick();
    check_fw("idle", 1, 8'hA5);
    drive_fw(1'b0, 1'b1, 8'h00); tick();
    check_fw("popA5", 0, 8'h00);
    drive_fw(1'b1, 1'b0, 8'hB1); tick();
    check_fw("wB1", 1, 8'hB1);
    drive_fw(1'b1, 1'b0, 8'hB2); tick();
    check_fw("wB2", 2, 8'hB1);
    drive_fw(1'b1, 1'b1, 8'hB3); tick();
    check_fw("pop_wB3", 2, 8'hB2);
    drive_fw(1'b0, 1'b1, 8'h00); tick();
    check_fw("popB2", 1, 8'hB3);
    drive_fw(1'b1, 1'b1, 8'hB4); tick();
    check_fw("pop_wB4", 1, 8'hB4);
    drive_fw(1'b0, 1'b1, 8'h00); tick();
    check_fw("popB4", 0, 8'h00);
    drive_fw(1'b0, 1'b0, 8'h00); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ext.md
FIFO_EXT -- requirements
Module: fifo_ext

Interface
REQ-001 SHALL have parameter data_word_size_g, default 8, giving the word width in bits (legal range 1 to 256).
REQ-002 SHALL have parameter num_fifo_elements_g, default 16, giving the depth; legal values are powers of two of at least 2, and any other value SHALL cause an elaboration error.
REQ-003 SHALL have parameter fwft_mode_g, default 0, selecting the read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter almost_full_thresh_g, default num_fifo_elements_g-2, in the range 1 to num_fifo_elements_g-1.
REQ-005 SHALL have parameter almost_empty_thresh_g, default 2, in the range 1 to num_fifo_elements_g-1.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port clk_en_i, input, 1 bit: clock enable; when 0, all state is held.
REQ-009 SHALL have port clr_i, input, 1 bit: synchronous flush, qualified by clk_en_i.
REQ-010 SHALL have port w_en_i, input, 1 bit: write request.
REQ-011 SHALL have port w_data_i, input, data_word_size_g bits: write data.
REQ-012 SHALL have port r_en_i, input, 1 bit: read request (pop in FWFT mode).
REQ-013 SHALL have port r_data_o, output, data_word_size_g bits: read data.
REQ-014 SHALL have port r_valid_o, output, 1 bit: r_data_o holds valid data.
REQ-015 SHALL have port w_full_o, output, 1 bit: asserted when level equals depth.
REQ-016 SHALL have port r_empty_o, output, 1 bit: asserted when level equals 0.
REQ-017 SHALL have port almost_full_o, output, 1 bit: asserted when level >= almost_full_thresh_g.
REQ-018 SHALL have port almost_empty_o, output, 1 bit: asserted when level <= almost_empty_thresh_g.
REQ-019 SHALL have port level_o, output, $clog2(num_fifo_elements_g)+1 bits: current occupancy, 0 to depth inclusive.
REQ-020 SHALL have ports overflow_o and underflow_o, each an output, 1 bit: sticky error flags.

Function
REQ-021 SHALL accept a write when clk_en_i=1, clr_i=0, w_en_i=1 and w_full_o=0; a write attempted while full is rejected even if a read is accepted in the same cycle.
REQ-022 SHALL accept a read when clk_en_i=1, clr_i=0, r_en_i=1 and r_empty_o=0.
REQ-023 SHALL change level on each cycle as follows: +1 for a write only, -1 for a read only, unchanged when both are accepted in the same cycle.
REQ-024 SHALL advance the write pointer and the read pointer by 1 per accepted access, wrapping from num_fifo_elements_g-1 to 0.
REQ-025 SHALL derive w_full_o, r_empty_o, almost_full_o, almost_empty_o and level_o only from registered state, with no combinational path from any input.
REQ-026 SHALL, in standard mode, load r_data_o with the head word on the clock edge that accepts a read (one-cycle latency), pulse r_valid_o high for exactly that following cycle, and otherwise hold r_data_o.
REQ-027 SHALL, in FWFT mode, present the head word on r_data_o whenever r_valid_o = NOT r_empty_o; a word written into an empty FIFO appears on the cycle after the write edge; the accepting edge of r_en_i pops the word and presents the next one.
REQ-028 SHALL set overflow_o on the edge at which w_en_i=1 while full, and set underflow_o on the edge at which r_en_i=1 while empty (clk_en_i=1, clr_i=0); each flag stays set until clr_i or reset.
REQ-029 SHALL, on clr_i=1 with clk_en_i=1, zero both pointers and the level, clear overflow_o, underflow_o and r_valid_o, and ignore any w_en_i or r_en_i in that cycle; memory contents are not cleared.
REQ-030 SHALL, when clk_en_i=0, ignore w_en_i, r_en_i and clr_i and hold all outputs.
REQ-031 SHALL update stored data only through accepted writes; rejected writes leave memory unchanged.

Reset
REQ-032 SHALL, on rst_i=0 and independent of clk_i, immediately drive: level_o=0, r_empty_o=1, w_full_o=0, almost_empty_o=1, almost_full_o=0, r_valid_o=0, r_data_o=0 (standard mode), overflow_o=0, underflow_o=0, and both pointers 0.
REQ-033 SHALL, on reset asserted mid-transfer, discard all stored words, and SHALL accept a write on the first rising edge after rst_i returns to 1.

Verification
REQ-034 Standard mode, depth 16: write 0x01..0x10 -> w_full_o=1 and level_o=16, almost_full_o=1 from level 14; a 17th write sets overflow_o and level_o stays 16.
REQ-035 Read 16 words back -> r_data_o = 0x01..0x10 in order, one cycle after each r_en_i, with r_valid_o pulsing; a further read sets underflow_o and r_empty_o=1.
REQ-036 Level 5 with simultaneous write and read for 20 cycles -> level_o stays 5, pointers wrap, and data order is preserved.
REQ-037 FWFT mode: write 0xA5 into an empty FIFO -> next cycle r_valid_o=1 and r_data_o=0xA5 with no r_en_i; pulse r_en_i -> r_valid_o=0.
REQ-038 Level 7 with clr_i=1 and w_en_i=1 in the same cycle -> level_o=0, r_empty_o=1, flags cleared, and no write accepted.
REQ-039 Level 9, assert rst_i=0 between clock edges -> all outputs reach their reset values before the next edge; hold clk_en_i=0 with w_en_i=1 -> level_o unchanged.
